// File: rtl/e_pkg.sv
// Shared types for the e-calc multiply slice: word format and the serial
// multiplier state encoding.
package e_pkg;

  localparam int WORD_W = 16;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MAC,
    COLEND,
    DONE
  } mulst_t;

endpackage

// File: rtl/e_mac16.sv
// Combinational multiply-accumulate: one 16x16 unsigned partial product
// added into the column accumulator. No registers inside.
module e_mac16
  import e_pkg::*;
#(
  parameter int ACC_W = 48
) (
  input  logic [ACC_W-1:0] i_acc_in,
  input  word_t            i_a,
  input  word_t            i_b,
  output logic [ACC_W-1:0] o_acc_out
);

  logic [2*WORD_W-1:0] w_prod;

  assign w_prod    = i_a * i_b;
  assign o_acc_out = i_acc_in + {{(ACC_W - 2*WORD_W){1'b0}}, w_prod};

endmodule

// File: rtl/e_multi_serial.sv
// Serial column-wise truncated fixed-point multiplier with a start/done
// handshake. Word 0 (integer word) sits in the most significant 16 bits.
module e_multi_serial
  import e_pkg::*;
#(
  parameter int WORDS = 32,
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [WORD_W*WORDS-1:0] A,
  input  logic [WORD_W*WORDS-1:0] B,
  output logic                    done,
  output logic                    busy,
  output logic [WORD_W*WORDS-1:0] product
);

  localparam int CNT_W = $clog2(2 * WORDS);
  localparam int IDX_W = $clog2(WORDS);
  localparam logic [CNT_W-1:0] K_MAX = CNT_W'(2 * WORDS - 2);
  localparam logic [CNT_W-1:0] I_MAX = CNT_W'(WORDS - 1);
  localparam logic [CNT_W-1:0] K_LIM = CNT_W'(WORDS);

  if (WORDS < 2 || WORDS > 65535) begin : g_bad_words
    $error("e_multi_serial: WORDS must be in 2..65535");
  end
  if (ACC_W < 2 * WORD_W + $clog2(WORDS) + 1) begin : g_bad_acc
    $error("e_multi_serial: ACC_W too narrow for WORDS");
  end

  mulst_t           r_state;
  logic [CNT_W-1:0] r_k;
  logic [CNT_W-1:0] r_i;
  logic [ACC_W-1:0] r_acc;
  word_t            r_op_a    [WORDS];
  word_t            r_op_b    [WORDS];
  word_t            r_product [WORDS];

  logic [CNT_W-1:0] w_j;
  logic [CNT_W-1:0] w_i_lo;
  logic [CNT_W-1:0] w_k_dec;
  word_t            w_a;
  word_t            w_b;
  logic [ACC_W-1:0] w_acc_next;

  // Column k pairs opA[i] with opB[k-i]; i walks down to the lowest legal index.
  assign w_j     = r_k - r_i;
  assign w_i_lo  = (r_k > I_MAX) ? r_k - I_MAX : '0;
  assign w_k_dec = r_k - 1'b1;
  assign w_a     = r_op_a[r_i[IDX_W-1:0]];
  assign w_b     = r_op_b[w_j[IDX_W-1:0]];

  e_mac16 #(.ACC_W(ACC_W)) u_mac (
    .i_acc_in  (r_acc),
    .i_a       (w_a),
    .i_b       (w_b),
    .o_acc_out (w_acc_next)
  );

  // NOTE: operand copies are pure datapath storage, always written in LOAD
  // before use, so they carry no reset and live in their own block.
  always_ff @(posedge clk) begin
    if (r_state == LOAD) begin
      for (int n = 0; n < WORDS; n++) begin
        r_op_a[n] <= A[WORD_W*(WORDS-1-n) +: WORD_W];
        r_op_b[n] <= B[WORD_W*(WORDS-1-n) +: WORD_W];
      end
    end
  end

  // NOTE: product words are visible on the port in IDLE, so unlike the
  // operand copies they are cleared by reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_k     <= '0;
      r_i     <= '0;
      r_acc   <= '0;
      done    <= 1'b0;
      busy    <= 1'b0;
      for (int n = 0; n < WORDS; n++) r_product[n] <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            r_state <= LOAD;
            busy    <= 1'b1;
          end
        end
        LOAD: begin
          r_k     <= K_MAX;
          r_i     <= I_MAX;
          r_acc   <= '0;
          r_state <= MAC;
        end
        MAC: begin
          r_acc <= w_acc_next;
          if (r_i == w_i_lo) r_state <= COLEND;
          else               r_i     <= r_i - 1'b1;
        end
        COLEND: begin
          if (r_k < K_LIM) r_product[r_k[IDX_W-1:0]] <= r_acc[WORD_W-1:0];
          r_acc <= r_acc >> WORD_W;
          if (r_k == '0) begin
            r_state <= DONE;
            done    <= 1'b1;
            busy    <= 1'b0;
          end else begin
            r_k     <= w_k_dec;
            r_i     <= (w_k_dec > I_MAX) ? I_MAX : w_k_dec;
            r_state <= MAC;
          end
        end
        DONE: begin
          done    <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    product = '0;
    for (int n = 0; n < WORDS; n++) product[WORD_W*(WORDS-1-n) +: WORD_W] = r_product[n];
  end

endmodule

// File: tb/tb_e_multi_serial.sv
// Bench for e_multi_serial at WORDS=2: directed operand pairs, expected
// products queued at issue and compared by a monitor whenever done pulses.
module tb_e_multi_serial;

  localparam int WORDS = 2;
  localparam int ACC_W = 48;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [31:0] A;
  logic [31:0] B;
  logic        done;
  logic        busy;
  logic [31:0] product;

  int n_cmp;
  int n_err;
  int n_done;
  logic [31:0] sb[$];

  e_multi_serial #(.WORDS(WORDS), .ACC_W(ACC_W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .A       (A),
    .B       (B),
    .done    (done),
    .busy    (busy),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && done) begin
      n_done++;
      check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) check("product", product, sb.pop_front());
    end
  end

  // Called just after a clock edge; counts further edges until done appears.
  task automatic wait_done(output int cyc, output int bcnt);
    cyc  = 0;
    bcnt = busy ? 1 : 0;
    while (!done && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
      if (busy) bcnt++;
    end
    check("done_seen", 32'(done), 32'd1);
  endtask

  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int cyc, bcnt;
    @(negedge clk);
    A     = a;
    B     = b;
    start = 1'b1;
    sb.push_back(exp);
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(cyc, bcnt);
    check({tag, "_latency"}, 32'(cyc), 32'd8);
    check({tag, "_busy_cycles"}, 32'(bcnt), 32'd8);
    @(posedge clk);
    #1;
    check({tag, "_done_width"}, 32'(done), 32'd0);
  endtask

  initial begin
    int cyc, bcnt, done_before;
    n_cmp = 0;
    n_err = 0;
    n_done = 0;
    rst_n = 1'b0;
    start = 1'b0;
    A     = '0;
    B     = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_product", product, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_busy", 32'(busy), 32'd0);

    // 1.5^2 = 2.25; 0.FFFF^2 truncated; 256^2 wraps the integer word.
    do_op("sq_1p5",  32'h0001_8000, 32'h0001_8000, 32'h0002_4000);
    do_op("sq_ffff", 32'h0000_FFFF, 32'h0000_FFFF, 32'h0000_FFFE);
    do_op("sq_wrap", 32'h0100_0000, 32'h0100_0000, 32'h0000_0000);
    do_op("mix",     32'h0003_0000, 32'h0002_8000, 32'h0007_8000);
    do_op("ulp",     32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_FFFF);
    do_op("max",     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFE_0000);

    // start held high; operands change after LOAD; second op only from IDLE.
    done_before = n_done;
    @(negedge clk);
    A     = 32'h0001_8000;
    B     = 32'h0001_8000;
    start = 1'b1;
    sb.push_back(32'h0002_4000);
    @(posedge clk);
    @(posedge clk);
    #1;
    A = 32'h0000_FFFF;
    B = 32'h0000_FFFF;
    wait_done(cyc, bcnt);
    check("held_latency", 32'(cyc), 32'd7);
    @(posedge clk);
    #1;
    check("held_done_ignored_busy", 32'(busy), 32'd0);
    check("held_done_width", 32'(done), 32'd0);
    sb.push_back(32'h0000_FFFE);
    @(posedge clk);
    #1;
    check("held_restart_busy", 32'(busy), 32'd1);
    start = 1'b0;
    wait_done(cyc, bcnt);
    repeat (4) @(posedge clk);
    #1;
    check("held_done_count", 32'(n_done - done_before), 32'd2);

    // Asynchronous reset in the middle of MAC aborts with no done.
    done_before = n_done;
    @(negedge clk);
    A     = 32'h0003_0000;
    B     = 32'h0002_8000;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("abort_done", 32'(done), 32'd0);
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_product", product, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("abort_no_done", 32'(n_done - done_before), 32'd0);
    do_op("post_rst", 32'h0003_0000, 32'h0002_8000, 32'h0007_8000);

    repeat (5) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'd0);
    check("total_dones", 32'(n_done), 32'd9);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
